// File: rtl/div_share_pkg.sv
// Shared types and defaults for the divider-sharing controller.
// Latency: n/a (types, constants and a pure helper function only).
// Backpressure: n/a.
package div_share_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   localparam int DEF_NUM_REQ     = 2;
   localparam int DEF_WIDTH       = 32;
   localparam int DEF_DIV_LATENCY = 32;

   // Widest requester vector the one-hot helper can express.
   localparam int MAX_REQ = 32;

   function automatic logic [MAX_REQ-1:0] idx_to_onehot(input logic [31:0] idx);
      return MAX_REQ'(1) << idx;
   endfunction

endpackage

// File: rtl/div_share_ctrl_if.sv
// Requester-side bundle of the divider-sharing controller.
// Latency: n/a (wiring only).
// Backpressure: req is held by a requester until its done pulse; grant shows the current owner.
interface div_share_ctrl_if import div_share_pkg::*; #(
   parameter int NUM_REQ = DEF_NUM_REQ,
   parameter int WIDTH   = DEF_WIDTH
);
   logic [NUM_REQ-1:0]       req;
   logic [NUM_REQ*WIDTH-1:0] dividend_in;
   logic [NUM_REQ*WIDTH-1:0] divisor_in;
   logic [NUM_REQ-1:0]       grant;
   logic [NUM_REQ-1:0]       done;
   logic [WIDTH-1:0]         quotient;
   logic [WIDTH-1:0]         remainder;
   logic                     dz_err;
   logic                     busy;

   // Requesters drive the operands and requests.
   modport master (
      output req, dividend_in, divisor_in,
      input  grant, done, quotient, remainder, dz_err, busy
   );

   // The controller returns ownership and results.
   modport slave (
      input  req, dividend_in, divisor_in,
      output grant, done, quotient, remainder, dz_err, busy
   );
endinterface

// File: rtl/div_share_ctrl_rr_arbiter.sv
// Round-robin pick: first set req at or after ptr, wrapping modulo NUM_REQ.
// Latency: combinational.
// Backpressure: none; gnt_vld is low when no request is pending.
module rr_arbiter import div_share_pkg::*; #(
   parameter int NUM_REQ = DEF_NUM_REQ
) (
   input  logic [NUM_REQ-1:0]         req,
   input  logic [$clog2(NUM_REQ)-1:0] ptr,
   output logic [NUM_REQ-1:0]         gnt_oh,
   output logic [$clog2(NUM_REQ)-1:0] gnt_idx,
   output logic                       gnt_vld
);
   localparam int IDXW = $clog2(NUM_REQ);

   int              cand;
   logic [IDXW-1:0] cand_idx;

   // Scan from the farthest offset down so the nearest request to ptr is the last one to win.
   always_comb begin
      gnt_vld  = 1'b0;
      gnt_idx  = '0;
      cand     = 0;
      cand_idx = '0;
      for (int off = NUM_REQ - 1; off >= 0; off--) begin
         cand = 32'(ptr) + off;
         if (cand >= NUM_REQ) begin
            cand = cand - NUM_REQ;
         end
         cand_idx = IDXW'(cand);
         if (req[cand_idx]) begin
            gnt_vld = 1'b1;
            gnt_idx = cand_idx;
         end
      end
      gnt_oh = gnt_vld ? NUM_REQ'(idx_to_onehot(32'(gnt_idx))) : '0;
   end
endmodule

// File: rtl/div_share_ctrl.sv
// Shares one free-running iterative divider between NUM_REQ requesters, round-robin.
// Latency: done DIV_LATENCY+1 cycles after the grant edge (1 cycle for divide-by-zero); one op per DIV_LATENCY+2 cycles.
// Backpressure: requests wait while busy; an owner dropping req aborts its op with no done.
module div_share_ctrl import div_share_pkg::*; #(
   parameter int NUM_REQ     = DEF_NUM_REQ,
   parameter int WIDTH       = DEF_WIDTH,
   parameter int DIV_LATENCY = DEF_DIV_LATENCY
) (
   input  logic             clk,
   input  logic             rst,
   div_share_ctrl_if.slave  bus,
   output logic [WIDTH-1:0] div_dividend,
   output logic [WIDTH-1:0] div_divisor,
   input  logic [WIDTH-1:0] div_quotient,
   input  logic [WIDTH-1:0] div_remainder
);
   localparam int IDXW = $clog2(NUM_REQ);
   localparam int CNTW = $clog2(DIV_LATENCY);
   localparam logic [CNTW-1:0] LAST_CNT = CNTW'(DIV_LATENCY - 1);

   state_t             state_q, state_d;
   logic [NUM_REQ-1:0] grant_q, grant_d;
   logic [IDXW-1:0]    owner_q, owner_d;
   logic [IDXW-1:0]    rr_ptr_q, rr_ptr_d;
   logic [CNTW-1:0]    count_q, count_d;
   logic [WIDTH-1:0]   opa_q, opa_d;
   logic [WIDTH-1:0]   opb_q, opb_d;
   logic [WIDTH-1:0]   quot_q, quot_d;
   logic [WIDTH-1:0]   rem_q, rem_d;
   logic               dz_q, dz_d;

   logic [NUM_REQ-1:0] arb_oh;
   logic [IDXW-1:0]    arb_idx;
   logic               arb_vld;
   logic [WIDTH-1:0]   win_a, win_b;
   logic               owner_req;
   logic [IDXW-1:0]    ptr_next;

   rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
      .req     (bus.req),
      .ptr     (rr_ptr_q),
      .gnt_oh  (arb_oh),
      .gnt_idx (arb_idx),
      .gnt_vld (arb_vld)
   );

   // Winner operand select, owner request sense and the pointer position just past the owner.
   always_comb begin
      win_a = '0;
      win_b = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (arb_idx == IDXW'(i)) begin
            win_a = bus.dividend_in[i*WIDTH +: WIDTH];
            win_b = bus.divisor_in[i*WIDTH +: WIDTH];
         end
      end
      owner_req = bus.req[owner_q];
      ptr_next  = (owner_q == IDXW'(NUM_REQ - 1)) ? '0 : owner_q + 1'b1;
   end

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next state: a zero divisor skips the divider; an owner dropping req aborts the run.
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: begin
            if (arb_vld) begin
               state_d = (win_b == '0) ? ST_DONE : ST_RUN;
            end
         end
         ST_RUN: begin
            if (!owner_req) begin
               state_d = ST_IDLE;
            end else if (count_q == LAST_CNT) begin
               state_d = ST_DONE;
            end
         end
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   // Datapath next values: operands frozen for the whole run, results held until the next capture.
   always_comb begin
      grant_d  = grant_q;
      owner_d  = owner_q;
      rr_ptr_d = rr_ptr_q;
      count_d  = count_q;
      opa_d    = opa_q;
      opb_d    = opb_q;
      quot_d   = quot_q;
      rem_d    = rem_q;
      dz_d     = dz_q;
      case (state_q)
         ST_IDLE: begin
            if (arb_vld) begin
               grant_d = arb_oh;
               owner_d = arb_idx;
               count_d = '0;
               opa_d   = win_a;
               opb_d   = win_b;
               if (win_b == '0) begin
                  quot_d = '1;
                  rem_d  = win_a;
                  dz_d   = 1'b1;
               end
            end
         end
         ST_RUN: begin
            if (!owner_req) begin
               grant_d  = '0;
               rr_ptr_d = ptr_next;
            end else if (count_q == LAST_CNT) begin
               quot_d = div_quotient;
               rem_d  = div_remainder;
               dz_d   = 1'b0;
            end else begin
               count_d = count_q + 1'b1;
            end
         end
         ST_DONE: begin
            grant_d  = '0;
            rr_ptr_d = ptr_next;
         end
         default: begin
            grant_d = '0;
         end
      endcase
   end

   // Datapath registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         grant_q  <= '0;
         owner_q  <= '0;
         rr_ptr_q <= '0;
         count_q  <= '0;
         opa_q    <= '0;
         opb_q    <= '0;
         quot_q   <= '0;
         rem_q    <= '0;
         dz_q     <= 1'b0;
      end else begin
         grant_q  <= grant_d;
         owner_q  <= owner_d;
         rr_ptr_q <= rr_ptr_d;
         count_q  <= count_d;
         opa_q    <= opa_d;
         opb_q    <= opb_d;
         quot_q   <= quot_d;
         rem_q    <= rem_d;
         dz_q     <= dz_d;
      end
   end

   // Outputs: done is the owner's grant qualified by the DONE state.
   always_comb begin
      bus.grant     = grant_q;
      bus.done      = grant_q & {NUM_REQ{state_q == ST_DONE}};
      bus.quotient  = quot_q;
      bus.remainder = rem_q;
      bus.dz_err    = dz_q;
      bus.busy      = (state_q != ST_IDLE);
      div_dividend  = opa_q;
      div_divisor   = opb_q;
   end
endmodule
